uart_tx_arbiter: RTL

//  Shares one UART transmitter between NUM_REQ packet sources. Each requester

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between packet sources, the arbiter and the UART transmitter.
// master = arbiter side, slave = the environment (sources + UART).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int BYTES   = 3
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*BYTES*8-1:0] pkt_data;
  logic [NUM_REQ-1:0]         ack;
  logic                       busy;
  logic [ID_W-1:0]            gnt_id;
  logic                       trmt;
  logic [7:0]                 tx_data;
  logic                       tx_done;

  modport master (
    input  req, pkt_data, tx_done,
    output ack, busy, gnt_id, trmt, tx_data
  );

  modport slave (
    output req, pkt_data, tx_done,
    input  ack, busy, gnt_id, trmt, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ packet sources.
// Define UART_ARB_CHKSUM_EN to append a two's-complement checksum byte to each packet.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int BYTES   = 3
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.master  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int PKT_W = BYTES * 8;
  localparam int CNT_W = $clog2(BYTES + 2);
`ifdef UART_ARB_CHKSUM_EN
  localparam int SR_W  = PKT_W + 8;
  localparam int LAST  = BYTES;
`else
  localparam int SR_W  = PKT_W;
  localparam int LAST  = BYTES - 1;
`endif

  typedef enum logic [2:0] {IDLE, GRANT, SEND, WAIT, DONE} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   pick;
  logic              pick_vld;
  logic [SR_W-1:0]   pkt_sr;
  logic [SR_W-1:0]   sr_load;
  logic [CNT_W-1:0]  byte_cnt;
  logic              tx_done_q;
  logic              done_rise;
  logic [PKT_W-1:0]  pkt_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign pkt_arr[i] = bus.pkt_data[i*PKT_W +: PKT_W];
  end

  // Scan downwards so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    int idx;
    // NOTE: every comb output gets a default first, otherwise a latch is inferred.
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (bus.req[ID_W'(idx)]) begin
        pick     = ID_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

`ifdef UART_ARB_CHKSUM_EN
  logic [7:0] sum;

  // Checksum byte makes all transmitted bytes of the packet sum to 0x00.
  always_comb begin
    sum = '0;
    for (int b = 0; b < BYTES; b++) sum = sum + pkt_arr[sel][b*8 +: 8];
    sr_load = {pkt_arr[sel], 8'h00 - sum};
  end
`else
  assign sr_load = pkt_arr[sel];
`endif

  // tx_done is a level that the UART clears on trmt; only a fresh 0->1 edge counts.
  assign done_rise = bus.tx_done & ~tx_done_q;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      sel         <= '0;
      // NOTE: the datapath shift register is reset too, so tx_data never shows stale packet bytes.
      pkt_sr      <= '0;
      byte_cnt    <= '0;
      tx_done_q   <= 1'b0;
      bus.ack     <= '0;
      bus.busy    <= 1'b0;
      bus.gnt_id  <= '0;
      bus.trmt    <= 1'b0;
      bus.tx_data <= '0;
    end else begin
      tx_done_q <= bus.tx_done;
      bus.trmt  <= 1'b0;
      bus.ack   <= '0;
      case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          if (pick_vld) begin
            sel   <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          pkt_sr     <= sr_load;
          bus.gnt_id <= sel;
          bus.busy   <= 1'b1;
          byte_cnt   <= '0;
          state      <= SEND;
        end
        SEND: begin
          bus.tx_data <= pkt_sr[SR_W-1 -: 8];
          bus.trmt    <= 1'b1;
          state       <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            pkt_sr   <= pkt_sr << 8;
            byte_cnt <= byte_cnt + CNT_W'(1);
            state    <= (byte_cnt == CNT_W'(LAST)) ? DONE : SEND;
          end
        end
        DONE: begin
          bus.ack[bus.gnt_id] <= 1'b1;
          rr_ptr <= (bus.gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : bus.gnt_id + ID_W'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
